// File: rtl/wash_pkg.sv
// Shared definitions for the wash sequencer: stage codes, program IDs,
// step counts, controller states and the stage duration table.
package wash_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_BP   = 4'd1,
    ST_EP   = 4'd2,
    ST_PP   = 4'd3,
    ST_PS   = 4'd4,
    ST_SF   = 4'd5,
    ST_C    = 4'd6,
    ST_RI   = 4'd7,
    ST_UU   = 4'd8,
    ST_D    = 4'd9,
    ST_RS   = 4'd10,
    ST_SH   = 4'd11,
    ST_FIN  = 4'd12
  } stage_t;

  typedef enum logic [1:0] {
    PROG_NONE    = 2'd0,
    PROG_BASIC   = 2'd1,
    PROG_EXTRA   = 2'd2,
    PROG_PREMIUM = 2'd3
  } prog_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  localparam logic [3:0] STEPS_BASIC   = 4'd4;
  localparam logic [3:0] STEPS_EXTRA   = 4'd6;
  localparam logic [3:0] STEPS_PREMIUM = 4'd12;

  function automatic logic [3:0] stage_dur(stage_t s);
    case (s)
      ST_BP, ST_EP, ST_PP:  return 4'd2;
      ST_PS:                return 4'd2;
      ST_SF:                return 4'd4;
      ST_C:                 return 4'd3;
      ST_RI:                return 4'd3;
      ST_UU:                return 4'd2;
      ST_D:                 return 4'd4;
      ST_RS:                return 4'd2;
      ST_SH:                return 4'd2;
      default:              return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] prog_steps(prog_t p);
    case (p)
      PROG_BASIC:   return STEPS_BASIC;
      PROG_EXTRA:   return STEPS_EXTRA;
      PROG_PREMIUM: return STEPS_PREMIUM;
      default:      return 4'd0;
    endcase
  endfunction

  // Fixed priority: basic over extra over premium.
  function automatic prog_t select_prog(logic sw7, logic sw6, logic sw5);
    if (sw7)      return PROG_BASIC;
    else if (sw6) return PROG_EXTRA;
    else if (sw5) return PROG_PREMIUM;
    else          return PROG_NONE;
  endfunction

endpackage

// File: rtl/wash_sequencer_if.sv
// Front-panel bundle of the wash sequencer: buttons, switches, time base
// and the status outputs.
interface wash_sequencer_if;
  logic       BTN3;
  logic       BTN0;
  logic       SW7;
  logic       SW6;
  logic       SW5;
  logic       tick;
  logic [3:0] stage;
  logic [3:0] remaining;
  logic       busy;
  logic       done;

  modport master (
    output BTN3, BTN0, SW7, SW6, SW5, tick,
    input  stage, remaining, busy, done
  );

  modport slave (
    input  BTN3, BTN0, SW7, SW6, SW5, tick,
    output stage, remaining, busy, done
  );
endinterface

// File: rtl/wash_program_rom.sv
// Combinational program table: (program, step) -> stage code, its duration
// and whether this is the program's final step.
module wash_program_rom
  import wash_pkg::*;
(
  input  prog_t      prog,
  input  logic [3:0] step,
  output stage_t     stage,
  output logic [3:0] duration,
  output logic       last_step
);

  always_comb begin
    stage = ST_IDLE;
    case (prog)
      PROG_BASIC: begin
        case (step)
          4'd0:    stage = ST_BP;
          4'd1:    stage = ST_SF;
          4'd2:    stage = ST_C;
          4'd3:    stage = ST_RI;
          default: stage = ST_IDLE;
        endcase
      end
      PROG_EXTRA: begin
        case (step)
          4'd0:    stage = ST_EP;
          4'd1:    stage = ST_PS;
          4'd2:    stage = ST_C;
          4'd3:    stage = ST_SF;
          4'd4:    stage = ST_C;
          4'd5:    stage = ST_RI;
          default: stage = ST_IDLE;
        endcase
      end
      PROG_PREMIUM: begin
        case (step)
          4'd0:    stage = ST_PP;
          4'd1:    stage = ST_PS;
          4'd2:    stage = ST_C;
          4'd3:    stage = ST_SF;
          4'd4:    stage = ST_C;
          4'd5:    stage = ST_RI;
          4'd6:    stage = ST_UU;
          4'd7:    stage = ST_C;
          4'd8:    stage = ST_RI;
          4'd9:    stage = ST_D;
          4'd10:   stage = ST_RS;
          4'd11:   stage = ST_SH;
          default: stage = ST_IDLE;
        endcase
      end
      default: stage = ST_IDLE;
    endcase
  end

  assign duration  = stage_dur(stage);
  assign last_step = (step == prog_steps(prog) - 4'd1);

endmodule

// File: rtl/wash_sequencer.sv
// Wash program sequencer: synchronised buttons, IDLE/RUN/FINISH controller
// and per-stage tick countdown.
module wash_sequencer
  import wash_pkg::*;
#(
  parameter bit TICK_SYNC = 1'b1
) (
  input logic             clk,
  input logic             rst,
  wash_sequencer_if.slave bus
);

  logic [1:0] start_sync, abort_sync;
  logic       start_prev, abort_prev;
  logic       start_edge, abort_edge;
  logic       primed, start_arm, abort_arm;
  logic       tick_int;

  state_t     state;
  prog_t      prog_q, sel_prog, rom_prog;
  logic [3:0] step, rom_step, rem_q, rom_dur;
  stage_t     stage_q, rom_stage;
  logic       busy_q, done_q, last_q, rom_last;

  // A button only arms after it has been seen released once out of reset,
  // so a button held through reset cannot start or abort anything.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_sync <= '0;
      abort_sync <= '0;
      start_prev <= 1'b0;
      abort_prev <= 1'b0;
      start_edge <= 1'b0;
      abort_edge <= 1'b0;
      primed     <= 1'b0;
      start_arm  <= 1'b0;
      abort_arm  <= 1'b0;
    end else begin
      start_sync <= {start_sync[0], bus.BTN3};
      abort_sync <= {abort_sync[0], bus.BTN0};
      start_prev <= start_sync[1];
      abort_prev <= abort_sync[1];
      start_edge <= start_arm & start_sync[1] & ~start_prev;
      abort_edge <= abort_arm & abort_sync[1] & ~abort_prev;
      primed     <= 1'b1;
      start_arm  <= start_arm | (primed & ~start_sync[0]);
      abort_arm  <= abort_arm | (primed & ~abort_sync[0]);
    end
  end

  generate
    if (TICK_SYNC) begin : g_tick_direct
      assign tick_int = bus.tick;
    end else begin : g_tick_sync
      logic [2:0] tick_sync;
      always_ff @(posedge clk) begin
        if (rst) tick_sync <= '0;
        else     tick_sync <= {tick_sync[1:0], bus.tick};
      end
      assign tick_int = tick_sync[1] & ~tick_sync[2];
    end
  endgenerate

  // In IDLE the table is addressed with the candidate program's first step;
  // otherwise it looks one step ahead so a reload is ready on the last tick.
  assign sel_prog = select_prog(bus.SW7, bus.SW6, bus.SW5);
  assign rom_prog = (state == S_IDLE) ? sel_prog : prog_q;
  assign rom_step = (state == S_IDLE) ? 4'd0 : step + 4'd1;

  wash_program_rom u_rom (
    .prog      (rom_prog),
    .step      (rom_step),
    .stage     (rom_stage),
    .duration  (rom_dur),
    .last_step (rom_last)
  );

  // NOTE: every register in this block uses <= so all of them see the
  // pre-edge values; mixing in = here would create ordering races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      prog_q  <= PROG_NONE;
      step    <= '0;
      stage_q <= ST_IDLE;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_edge && sel_prog != PROG_NONE) begin
            state   <= S_RUN;
            prog_q  <= sel_prog;
            step    <= '0;
            stage_q <= rom_stage;
            rem_q   <= rom_dur;
            last_q  <= rom_last;
            busy_q  <= 1'b1;
          end
        end
        S_RUN: begin
          if (abort_edge) begin
            state   <= S_IDLE;
            step    <= '0;
            stage_q <= ST_IDLE;
            rem_q   <= '0;
            busy_q  <= 1'b0;
          end else if (tick_int) begin
            if (rem_q == 4'd1) begin
              if (last_q) begin
                state   <= S_FINISH;
                stage_q <= ST_FIN;
                rem_q   <= '0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                step    <= step + 4'd1;
                stage_q <= rom_stage;
                rem_q   <= rom_dur;
                last_q  <= rom_last;
              end
            end else begin
              rem_q <= rem_q - 4'd1;
            end
          end
        end
        S_FINISH: begin
          if (start_edge) begin
            state   <= S_IDLE;
            step    <= '0;
            stage_q <= ST_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.stage     = stage_q;
  assign bus.remaining = rem_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// Scoreboard bench for wash_sequencer: a program-level model queues the
// expected output states, a monitor compares each observed output change.
module tb_wash_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wash_sequencer_if bus ();

  wash_sequencer #(.TICK_SYNC(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [3:0] stage;
    logic [3:0] rem;
    logic       busy;
    logic       done;
  } out_t;

  out_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  int dur_tab[13] = '{0, 2, 2, 2, 2, 4, 3, 3, 2, 4, 2, 2, 0};
  int seq_b[4]    = '{1, 5, 6, 7};
  int seq_e[6]    = '{2, 4, 6, 5, 6, 7};
  int seq_p[12]   = '{3, 4, 6, 5, 6, 7, 8, 6, 7, 9, 10, 11};

  // model: 0 idle, 1 running, 2 finished
  int m_state = 0;
  int m_prog  = 0;
  int m_step  = 0;
  int m_rem   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int prog_len(int p);
    case (p)
      1: return 4;
      2: return 6;
      3: return 12;
      default: return 0;
    endcase
  endfunction

  function automatic int prog_stage(int p, int i);
    case (p)
      1: return seq_b[i];
      2: return seq_e[i];
      3: return seq_p[i];
      default: return 0;
    endcase
  endfunction

  function automatic int pick_prog();
    if (bus.SW7) return 1;
    if (bus.SW6) return 2;
    if (bus.SW5) return 3;
    return 0;
  endfunction

  function automatic out_t cur();
    out_t o;
    o.stage = bus.stage;
    o.rem   = bus.remaining;
    o.busy  = bus.busy;
    o.done  = bus.done;
    return o;
  endfunction

  task automatic push(input int s, input int r, input int b, input int d);
    out_t e;
    e.stage = 4'(s);
    e.rem   = 4'(r);
    e.busy  = 1'(b);
    e.done  = 1'(d);
    sb.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_tick();
    if (m_state != 1) return;
    if (m_rem > 1) begin
      m_rem--;
      push(prog_stage(m_prog, m_step), m_rem, 1, 0);
    end else if (m_step == prog_len(m_prog) - 1) begin
      m_state = 2;
      push(12, 0, 0, 1);
      push(12, 0, 0, 0);
    end else begin
      m_step++;
      m_rem = dur_tab[prog_stage(m_prog, m_step)];
      push(prog_stage(m_prog, m_step), m_rem, 1, 0);
    end
  endtask

  // The button acts on the 4th edge after it is raised (sampled at the 1st).
  task automatic press_start(input bit tick_at_edge);
    int  p;
    bit  exp_start, exp_exit;
    logic [3:0] early_stage;
    logic       early_busy;
    p         = pick_prog();
    exp_start = (m_state == 0) && (p != 0);
    exp_exit  = (m_state == 2);
    if (exp_start) begin
      m_state = 1;
      m_prog  = p;
      m_step  = 0;
      m_rem   = dur_tab[prog_stage(p, 0)];
      push(prog_stage(p, 0), m_rem, 1, 0);
    end else if (exp_exit) begin
      m_state = 0;
      push(0, 0, 0, 0);
    end
    bus.BTN3 = 1'b1;
    cyc(3);
    early_busy  = bus.busy;
    early_stage = bus.stage;
    if (tick_at_edge) bus.tick = 1'b1;
    cyc(1);
    bus.tick = 1'b0;
    if (exp_start) begin
      check("start_latency_early", 32'(early_busy), 0);
      check("start_latency", 32'(bus.busy), 1);
    end
    if (exp_exit) begin
      check("fin_exit_early", 32'(early_stage), 12);
      check("fin_exit", 32'(bus.stage), 0);
    end
    bus.BTN3 = 1'b0;
    cyc(4);
  endtask

  task automatic press_abort(input bit tick_at_edge);
    if (m_state == 1) begin
      m_state = 0;
      push(0, 0, 0, 0);
    end
    bus.BTN0 = 1'b1;
    cyc(3);
    if (tick_at_edge) bus.tick = 1'b1;
    cyc(1);
    bus.tick = 1'b0;
    bus.BTN0 = 1'b0;
    cyc(4);
  endtask

  task automatic do_tick();
    model_tick();
    bus.tick = 1'b1;
    cyc(1);
    bus.tick = 1'b0;
    cyc($urandom_range(0, 2));
  endtask

  task automatic run_to_end();
    int guard = 0;
    while (m_state == 1 && guard < 100) begin
      do_tick();
      guard++;
    end
  endtask

  task automatic do_reset();
    if (m_state != 0) push(0, 0, 0, 0);
    m_state = 0;
    m_step  = 0;
    m_rem   = 0;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(3);
  endtask

  task automatic set_sw(input bit s7, input bit s6, input bit s5);
    bus.SW7 = s7;
    bus.SW6 = s6;
    bus.SW5 = s5;
  endtask

  // Monitor: every change of the output tuple must match the next queued entry.
  initial begin
    out_t prev, c, e;
    wait (mon_en);
    prev = cur();
    forever begin
      @(negedge clk);
      c = cur();
      if (c != prev) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected actual=%0h required=no_change", c);
        end else begin
          e = sb.pop_front();
          check("sb_output", 32'(c), 32'(e));
        end
        prev = c;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    bus.BTN3 = 1'b0;
    bus.BTN0 = 1'b0;
    bus.tick = 1'b0;
    set_sw(0, 0, 0);
    cyc(3);
    rst = 1'b0;
    check("reset_stage", 32'(bus.stage), 0);
    check("reset_remaining", 32'(bus.remaining), 0);
    check("reset_busy", 32'(bus.busy), 0);
    check("reset_done", 32'(bus.done), 0);
    mon_en = 1'b1;
    cyc(3);

    // basic program, tick coincident with the start edge is ignored
    set_sw(1, 0, 0);
    press_start(1'b1);
    run_to_end();
    check("basic_fin_stage", 32'(bus.stage), 12);
    press_abort(1'b1);
    check("fin_ignores_abort", 32'(bus.stage), 12);
    press_start(1'b0);

    // priority and no-switch start
    set_sw(1, 0, 1);
    press_start(1'b0);
    check("prio_first_stage", 32'(bus.stage), 1);
    press_abort(1'b0);
    set_sw(0, 0, 0);
    press_start(1'b0);
    check("no_switch_idle", 32'(bus.busy), 0);

    // premium, abort coincident with a tick during the fifth step
    set_sw(0, 0, 1);
    press_start(1'b0);
    while (m_state == 1 && m_step < 4) do_tick();
    press_abort(1'b1);
    check("abort_remaining", 32'(bus.remaining), 0);
    check("abort_stage", 32'(bus.stage), 0);

    // finish, exit to idle, restart with extra
    set_sw(1, 0, 0);
    press_start(1'b0);
    run_to_end();
    press_start(1'b0);
    set_sw(0, 1, 0);
    press_start(1'b0);
    check("restart_stage", 32'(bus.stage), 2);
    check("restart_remaining", 32'(bus.remaining), 2);

    // reset during extra step 3 with start held through reset
    while (m_state == 1 && m_step < 3) do_tick();
    bus.BTN3 = 1'b1;
    cyc(1);
    do_reset();
    cyc(8);
    check("held_no_start", 32'(bus.busy), 0);
    check("held_stage", 32'(bus.stage), 0);
    bus.BTN3 = 1'b0;
    cyc(4);

    // switch change during a basic run leaves the sequence unchanged
    set_sw(1, 0, 0);
    press_start(1'b0);
    repeat (3) do_tick();
    set_sw(0, 0, 1);
    run_to_end();
    press_start(1'b0);

    // randomized runs
    for (int it = 0; it < 10; it++) begin
      int n;
      set_sw(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      press_start(1'($urandom_range(0, 1)));
      n = $urandom_range(0, 40);
      for (int k = 0; k < n && m_state == 1; k++) do_tick();
      if (m_state == 1 && $urandom_range(0, 1) == 1) press_abort(1'($urandom_range(0, 1)));
      if (m_state == 1) run_to_end();
      if (m_state == 2) press_start(1'b0);
    end

    cyc(5);
    check("sb_drained", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wash_sequencer.md
WASH_SEQUENCER -- requirements
Module: wash_sequencer

Interface
REQ-001 Parameter: TICK_SYNC, default 1, meaning tick input already synchronous to clk (no resynchronisation applied).
REQ-002 Ports: clk in 1 system clock; rst in 1 reset (one clock; reset is synchronous and active-high).
REQ-003 Ports: BTN3 in 1 start/payment button, asynchronous level; BTN0 in 1 abort button, asynchronous level.
REQ-004 Ports: SW7 in 1 basic program select; SW6 in 1 extra program select; SW5 in 1 premium program select (all static levels).
REQ-005 Ports: tick in 1 one-cycle time-base pulse (nominal 1 Hz).
REQ-006 Ports: stage out 4 current stage code; remaining out 4 ticks left in current stage; busy out 1 high in RUN; done out 1 one-cycle completion pulse.

Function
REQ-007 BTN3 and BTN0 SHALL each pass a 2-flop synchroniser plus a registered rising-edge detector; an action takes effect on outputs 3 clk edges after the input is first sampled high.
REQ-008 Stage codes SHALL be: IDLE=0, BP=1, EP=2, PP=3, PS=4, SF=5, C=6, RI=7, UU=8, D=9, RS=10, SH=11, FIN=12.
REQ-009 Programs SHALL be: basic = BP,SF,C,RI (4 steps); extra = EP,PS,C,SF,C,RI (6 steps); premium = PP,PS,C,SF,C,RI,UU,C,RI,D,RS,SH (12 steps).
REQ-010 Stage durations in ticks SHALL be: BP/EP/PP 2, PS 2, SF 4, C 3, RI 3, UU 2, D 4, RS 2, SH 2.
REQ-011 Controller states SHALL be IDLE, RUN, FINISH.
REQ-012 IDLE: on BTN3 edge, program SHALL be selected with priority SW7 > SW6 > SW5 and latched; if no switch is set, the edge is ignored and the controller stays IDLE.
REQ-013 IDLE->RUN: step = 0, stage = first stage of the latched program, remaining = its duration, busy = 1.
REQ-014 RUN: each tick SHALL decrement remaining; a tick with remaining = 1 SHALL advance step and reload remaining with the new stage duration in the same edge.
REQ-015 A tick with remaining = 1 on the last step SHALL enter FINISH: stage = FIN, remaining = 0, busy = 0, done = 1 for exactly that one cycle.
REQ-016 BTN0 edge in RUN SHALL return to IDLE on the next edge (stage = 0, remaining = 0, busy = 0, no done pulse); abort wins over a simultaneous tick.
REQ-017 A tick in the same cycle as the IDLE->RUN transition SHALL be ignored; the first decrement occurs on a later tick.
REQ-018 Switch changes during RUN or FINISH SHALL have no effect.
REQ-019 BTN3 edges during RUN SHALL be ignored.
REQ-020 FINISH: holds stage = FIN until a BTN3 edge, which SHALL go to IDLE only (a new BTN3 edge is needed to start again); BTN0 is ignored in FINISH.
REQ-021 In IDLE and FINISH, tick SHALL be ignored.

Reset
REQ-022 When rst = 1 at a clk edge: state = IDLE, stage = 0, remaining = 0, step = 0, busy = 0, done = 0, synchroniser and edge flops = 0, latched program cleared.
REQ-023 Reset mid-RUN SHALL abort without a done pulse; no button edge SHALL be detected in the first cycle after reset even if the button is held.

Structure
REQ-024 Stage code constants, program IDs, step counts and the duration table SHALL live in shared package wash_pkg.
REQ-025 Sub-module wash_program_rom (combinational: program, step -> stage, duration, last_step) SHALL hold the program sequences; the FSM, counters and synchronisers stay in wash_sequencer.

Verification
REQ-026 Basic: SW7 = 1, BTN3 pulse -> stage 1,5,6,7 for 2,4,3,3 ticks; done pulses once on the 12th tick; stage = 12.
REQ-027 Priority: SW7 = SW5 = 1, start -> basic sequence (first stage 1); all switches 0, start -> stays IDLE, busy = 0.
REQ-028 Abort: premium run, BTN0 edge coincident with a tick during step 5 -> IDLE, stage 0, no done pulse, remaining 0.
REQ-029 Finish/restart: in FINISH, BTN3 edge -> IDLE only; a second BTN3 edge with SW6 = 1 -> stage 2, remaining 2.
REQ-030 Mid-run reset: rst asserted during extra step 3 -> all outputs 0 next edge; BTN3 held through reset -> no start.
REQ-031 Latching: toggle SW7->SW5 during a basic run -> sequence unchanged, 4 steps total.
